dbg_capture_lut: RTL and testbench
==================================

// Module: dbg_capture_lut
// PURPOSE
// - Single-clock debug capture buffer in distributed (LUT) RAM with pre-/post-trigger windowing.
// - Software arms it, data streams in continuously, and a trigger freezes a DEPTH-sample window.
// - The window holds PRETRIG samples before the trigger, the trigger sample, and the rest after it.
// - Readback is in chronological order. Sits beside DSP taps in the debug subsystem; successor of the LUT RAM primitive.
// PARAMETERS
// - WIDTH    8     sample width, bits
// - DEPTH    16    window length, samples; power of two, >=4; AWIDTH = log2(DEPTH) via math.v
// - OUT_REG  0     "EN": registered read (1-cycle latency); any other value: combinational read
// PORTS
// - clk       in   1       single clock, rising edge
// - resetn    in   1       asynchronous, active-low reset
// - arm       in   1       1-cycle pulse: start/restart capture
// - pretrig   in   AWIDTH  pre-trigger sample count; sampled on arm; clamped to DEPTH-1
// - dat_vld   in   1       dat_in valid this cycle
// - dat_in    in   WIDTH   sample
// - trig      in   1       trigger; qualified by dat_vld
// - busy      out  1       state is PRE or POST
// - done      out  1       window frozen (state DONE)
// - trig_pos  out  AWIDTH  read index of the trigger sample (= latched pretrig)
// - rd_en     in   1       read request
// - rd_addr   in   AWIDTH  chronological index; 0 = oldest sample
// - rd_dat    out  WIDTH   read data
// - rd_vld    out  1       rd_dat valid
// BEHAVIOUR
// - Reset (async, resetn=0):
//   - state=IDLE; wr_ptr, cnt, trig_ptr, trig_pos = 0.
//   - busy, done, rd_vld, rd_dat = 0. RAM contents are not reset.
// - FSM states: IDLE -> PRE -> POST -> DONE.
//   - IDLE: arm -> PRE; wr_ptr<=0, cnt<=0, trig_pos<=min(pretrig,DEPTH-1). No writes in IDLE.
//   - PRE: each dat_vld writes ram[wr_ptr] and increments wr_ptr (wraps mod DEPTH).
//     - cnt counts written samples, saturating at trig_pos.
//     - trig&dat_vld with cnt==trig_pos: sample is the trigger sample; trig_ptr<=wr_ptr.
//       Next state POST, with cnt<=DEPTH-1-trig_pos remaining samples.
//     - trig with cnt<trig_pos: ignored (pre-fill incomplete).
//     - trig_pos==DEPTH-1: the window fills pre-trigger data, then waits for trig.
//   - POST: each dat_vld writes and decrements cnt.
//     - The write with cnt==1 -> DONE.
//     - cnt==0 on entry (trig_pos==DEPTH-1) -> DONE the next cycle with no further write.
//     - trig ignored.
//   - DONE: writes blocked, done=1; arm -> PRE, as in IDLE.
// - arm in PRE or POST restarts the capture (same as IDLE->PRE); arm wins over a same-cycle trig.
// - Total samples per window = trig_pos + 1 + (DEPTH-1-trig_pos) = DEPTH.
// - Read address: phys = trig_ptr - trig_pos + rd_addr, mod DEPTH.
//   - Reads are legal in any state; data is meaningful only when done=1.
// - OUT_REG=="EN":
//   - rd_dat <= rd_en ? ram[phys] : 0; rd_vld <= rd_en.
//   - Latency 1 clk; rd_dat is forced to 0 when not reading.
// - Otherwise: rd_dat = ram[phys] combinationally; rd_vld = rd_en.
// - Same-cycle write and read of one address: read returns old data. This only occurs outside DONE.
// - Pointer arithmetic is AWIDTH-bit, wrapping; no overflow flags.
// STRUCTURE
// - Shared include dbg_pkg.vh:
//   - state localparams DBG_IDLE=2'd0, DBG_PRE=2'd1, DBG_POST=2'd2, DBG_DONE=2'd3.
//   - OUT_REG mode string constant.
// - math.v supplies log2.
// - Sub-module lutram_sdp (WIDTH, DEPTH):
//   - single-clock simple dual-port RAM, ram_style="distributed".
//   - synchronous write, asynchronous read.
//   - The FSM, pointers and the output register live in the top level.
// TESTING (WIDTH=8, DEPTH=16; data = incrementing counter from 0, dat_vld=1 every cycle)
// 1. Reset: resetn=0 mid-run -> busy=done=rd_vld=0, rd_dat=0 within the same cycle (async).
// 2. Nominal: arm, pretrig=4, trig with sample 10.
//    -> done rises after sample 21; trig_pos=4.
//    -> rd_addr 0..15 returns 6..21; rd_addr 4 returns 10.
// 3. Early trigger: pretrig=8, trig with sample 2 -> ignored, busy=1.
//    trig with sample 12 -> window 4..19.
// 4. Re-arm mid-POST, pretrig=2:
//    -> cnt restarts, done never asserts for the aborted window.
//    -> trig after 2 samples gives a valid new window.
// 5. OUT_REG="EN":
//    -> rd_vld and rd_dat lag rd_en by 1 clk; rd_en=0 -> rd_dat=0.
//    OUT_REG=0 -> same-cycle data.
// 6. Gapped dat_vld (1 of 3 cycles) with trig held high:
//    -> trigger taken only on a valid sample; window contents identical to test 2 ordering.

Source files
------------

// File: rtl/dbg_capture_lut_pkg.sv
// Shared types and constants for the debug capture buffer: FSM state
// encoding, the registered-read mode tag and a constant log2 helper.
package dbg_capture_lut_pkg;

  typedef enum logic [1:0] {
    DBG_IDLE = 2'd0,
    DBG_PRE  = 2'd1,
    DBG_POST = 2'd2,
    DBG_DONE = 2'd3
  } dbg_state_e;

  // OUT_REG value that selects the registered (1-cycle) read path.
  localparam logic [15:0] OUT_REG_EN = "EN";

  // Ceiling log2, usable in constant expressions.
  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/dbg_capture_lut_lutram_sdp.sv
// Single-clock simple dual-port distributed RAM: synchronous write,
// asynchronous read (read-during-write returns the old word).
module dbg_capture_lut_lutram_sdp
  import dbg_capture_lut_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  localparam int AWIDTH = log2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AWIDTH-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [AWIDTH-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  (* ram_style = "distributed" *) logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage arrays take no reset; a reset would stop the tools mapping them to LUT RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dbg_capture_lut.sv
// Debug capture buffer: arm, stream samples, freeze a DEPTH-sample window
// around a trigger, then read it back in chronological order.
module dbg_capture_lut
  import dbg_capture_lut_pkg::*;
#(
  parameter  int          WIDTH   = 8,
  parameter  int          DEPTH   = 16,
  parameter  logic [15:0] OUT_REG = 16'd0,
  localparam int          AWIDTH  = log2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              arm,
  input  logic [AWIDTH-1:0] pretrig,
  input  logic              dat_vld,
  input  logic [WIDTH-1:0]  dat_in,
  input  logic              trig,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] trig_pos,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_dat,
  output logic              rd_vld
);

  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);
  localparam logic [AWIDTH-1:0] ONE  = AWIDTH'(1);

  dbg_state_e        r_state;
  logic [AWIDTH-1:0] r_wr_ptr;
  logic [AWIDTH-1:0] r_cnt;
  logic [AWIDTH-1:0] r_trig_ptr;
  logic [AWIDTH-1:0] r_trig_pos;
  logic              r_busy;
  logic              r_done;

  logic              w_we;
  logic [AWIDTH-1:0] w_phys;
  logic [WIDTH-1:0]  w_ram_dat;

  // An arm cycle never stores its sample; POST with zero samples left only
  // spends one cycle on the way to DONE.
  assign w_we = dat_vld && !arm &&
                ((r_state == DBG_PRE) || ((r_state == DBG_POST) && (r_cnt != '0)));

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= DBG_IDLE;
      r_wr_ptr   <= '0;
      r_cnt      <= '0;
      r_trig_ptr <= '0;
      r_trig_pos <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (arm) begin
      // pretrig is AWIDTH wide, so it can never exceed DEPTH-1.
      r_state    <= DBG_PRE;
      r_wr_ptr   <= '0;
      r_cnt      <= '0;
      r_trig_pos <= pretrig;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        DBG_PRE: begin
          if (dat_vld) begin
            r_wr_ptr <= r_wr_ptr + ONE;
            if (trig && (r_cnt == r_trig_pos)) begin
              r_trig_ptr <= r_wr_ptr;
              r_cnt      <= LAST - r_trig_pos;
              r_state    <= DBG_POST;
            end else if (r_cnt != r_trig_pos) begin
              r_cnt <= r_cnt + ONE;
            end
          end
        end
        DBG_POST: begin
          if (r_cnt == '0) begin
            r_state <= DBG_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (dat_vld) begin
            r_wr_ptr <= r_wr_ptr + ONE;
            r_cnt    <= r_cnt - ONE;
            if (r_cnt == ONE) begin
              r_state <= DBG_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign trig_pos = r_trig_pos;

  // Chronological index 0 is the oldest sample, trig_pos entries before the trigger.
  assign w_phys = r_trig_ptr - r_trig_pos + rd_addr;

  dbg_capture_lut_lutram_sdp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (dat_in),
    .i_raddr (w_phys),
    .o_rdata (w_ram_dat)
  );

  generate
    if (OUT_REG == OUT_REG_EN) begin : g_rd_reg
      logic [WIDTH-1:0] r_rd_dat;
      logic             r_rd_vld;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_rd_dat <= '0;
          r_rd_vld <= 1'b0;
        end else begin
          r_rd_dat <= rd_en ? w_ram_dat : '0;
          r_rd_vld <= rd_en;
        end
      end

      assign rd_dat = r_rd_dat;
      assign rd_vld = r_rd_vld;
    end else begin : g_rd_comb
      assign rd_dat = w_ram_dat;
      assign rd_vld = rd_en;
    end
  endgenerate

endmodule

// File: tb/tb_dbg_capture_lut.sv
// Bench for dbg_capture_lut: a registered-read and a combinational-read
// instance share stimulus and are compared against a sample-history model.
module tb_dbg_capture_lut;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             resetn;
  logic             arm;
  logic [3:0]       pretrig;
  logic             dat_vld;
  logic [WIDTH-1:0] dat_in;
  logic             trig;
  logic             rd_en;
  logic [3:0]       rd_addr;

  logic             busy_r, done_r, rd_vld_r;
  logic             busy_c, done_c, rd_vld_c;
  logic [3:0]       tpos_r, tpos_c;
  logic [WIDTH-1:0] rd_dat_r, rd_dat_c;

  int n_checks = 0;
  int n_errors = 0;

  // Model: every sample accepted since the last arm, the trigger's index in
  // that history, and whether the window is complete.
  logic [WIDTH-1:0] hist[$];
  bit               m_armed;
  bit               m_done;
  bit               m_zero_post;
  int               m_tpos;
  int               m_tidx;

  always #5 clk = ~clk;

  dbg_capture_lut #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OUT_REG("EN")) u_reg (
    .clk(clk), .resetn(resetn), .arm(arm), .pretrig(pretrig),
    .dat_vld(dat_vld), .dat_in(dat_in), .trig(trig),
    .busy(busy_r), .done(done_r), .trig_pos(tpos_r),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_dat(rd_dat_r), .rd_vld(rd_vld_r)
  );

  dbg_capture_lut #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OUT_REG(16'd0)) u_comb (
    .clk(clk), .resetn(resetn), .arm(arm), .pretrig(pretrig),
    .dat_vld(dat_vld), .dat_in(dat_in), .trig(trig),
    .busy(busy_c), .done(done_c), .trig_pos(tpos_c),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_dat(rd_dat_c), .rd_vld(rd_vld_c)
  );

  task automatic model_reset();
    m_armed = 0; m_done = 0; m_zero_post = 0; m_tpos = 0; m_tidx = -1;
    hist.delete();
  endtask

  // One clock: drive at the falling edge, update the model at the rising
  // edge, then compare status at the next falling edge.
  task automatic drive_cycle(input string tag, input bit a, input bit v, input bit t,
                             input logic [3:0] p, input logic [WIDTH-1:0] d);
    bit exp_busy;
    arm = a; dat_vld = v; trig = t; pretrig = p; dat_in = d;
    @(posedge clk);
    if (a) begin
      model_reset();
      m_armed = 1; m_tpos = int'(p);
    end else if (m_armed && !m_done) begin
      if (m_zero_post) m_done = 1;
      else if (v) begin
        hist.push_back(d);
        if (m_tidx < 0 && t && hist.size() > m_tpos) m_tidx = hist.size() - 1;
        if (m_tidx >= 0) begin
          if (m_tpos == DEPTH - 1) m_zero_post = 1;
          else if (hist.size() == m_tidx + DEPTH - m_tpos) m_done = 1;
        end
      end
    end
    @(negedge clk);
    arm = 0; dat_vld = 0; trig = 0;
    exp_busy = m_armed && !m_done;
    n_checks++;
    if (busy_r !== exp_busy || busy_c !== exp_busy) begin
      n_errors++;
      $display("FAIL %s busy: got reg=%0b comb=%0b, expected %0b", tag, busy_r, busy_c, exp_busy);
    end
    n_checks++;
    if (done_r !== m_done || done_c !== m_done) begin
      n_errors++;
      $display("FAIL %s done: got reg=%0b comb=%0b, expected %0b", tag, done_r, done_c, m_done);
    end
    n_checks++;
    if (int'(tpos_r) !== m_tpos || int'(tpos_c) !== m_tpos) begin
      n_errors++;
      $display("FAIL %s trig_pos: got reg=%0d comb=%0d, expected %0d", tag, tpos_r, tpos_c, m_tpos);
    end
  endtask

  // Reads the whole frozen window through both read paths.
  task automatic test_readback(input string tag);
    int base;
    if (!m_done || m_tidx < 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s readback: window not complete (done=%0b), expected complete", tag, done_r);
      return;
    end
    base = m_tidx - m_tpos;
    for (int k = 0; k < DEPTH; k++) begin
      rd_en = 1; rd_addr = 4'(k);
      #1;
      n_checks++;
      if (rd_dat_c !== hist[base + k] || rd_vld_c !== 1'b1) begin
        n_errors++;
        $display("FAIL %s comb rd[%0d]: got %0h vld=%0b, expected %0h vld=1",
                 tag, k, rd_dat_c, rd_vld_c, hist[base + k]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (rd_dat_r !== hist[base + k] || rd_vld_r !== 1'b1) begin
        n_errors++;
        $display("FAIL %s reg rd[%0d]: got %0h vld=%0b, expected %0h vld=1",
                 tag, k, rd_dat_r, rd_vld_r, hist[base + k]);
      end
      @(negedge clk);
    end
    rd_en = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    resetn = 0; arm = 0; dat_vld = 0; trig = 0; pretrig = '0; dat_in = '0;
    rd_en = 0; rd_addr = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy_r !== 0 || done_r !== 0 || rd_vld_r !== 0 || rd_dat_r !== '0 || tpos_r !== '0) begin
      n_errors++;
      $display("FAIL reset_init: busy=%0b done=%0b rd_vld=%0b rd_dat=%0h trig_pos=%0d, expected all 0",
               busy_r, done_r, rd_vld_r, rd_dat_r, tpos_r);
    end
    resetn = 1;
    @(negedge clk);
    drive_cycle("reset_arm", 1, 0, 0, 4'd3, '0);
    for (int s = 0; s < 5; s++) drive_cycle("reset_run", 0, 1, 0, 4'd3, 8'(s));
    rd_en = 1; rd_addr = 4'd1;
    @(posedge clk); #2;
    resetn = 0;
    #1;
    n_checks++;
    if (busy_r !== 0 || busy_c !== 0 || done_r !== 0 || rd_vld_r !== 0 || rd_dat_r !== '0) begin
      n_errors++;
      $display("FAIL reset_async: busy=%0b/%0b done=%0b rd_vld=%0b rd_dat=%0h, expected all 0",
               busy_r, busy_c, done_r, rd_vld_r, rd_dat_r);
    end
    model_reset();
    rd_en = 0;
    @(negedge clk);
    resetn = 1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    int s;
    drive_cycle("nominal_arm", 1, 0, 0, 4'd4, '0);
    s = 0;
    while (done_r !== 1'b1 && s < 64) begin
      drive_cycle("nominal", 0, 1, s == 10, 4'd4, 8'(s));
      s++;
    end
    n_checks++;
    if (s - 1 != 21) begin
      n_errors++;
      $display("FAIL nominal_done_sample: done after sample %0d, expected 21", s - 1);
    end
    rd_addr = 4'd4; #1;
    n_checks++;
    if (rd_dat_c !== 8'd10) begin
      n_errors++;
      $display("FAIL nominal_trig_sample: got %0d, expected 10", rd_dat_c);
    end
    rd_addr = 4'd0; #1;
    n_checks++;
    if (rd_dat_c !== 8'd6) begin
      n_errors++;
      $display("FAIL nominal_oldest: got %0d, expected 6", rd_dat_c);
    end
    test_readback("nominal");
  endtask

  task automatic test_early_trig();
    int s;
    drive_cycle("early_arm", 1, 0, 0, 4'd8, '0);
    s = 0;
    while (done_r !== 1'b1 && s < 64) begin
      drive_cycle("early", 0, 1, (s == 2) || (s == 12), 4'd8, 8'(s));
      s++;
    end
    rd_addr = 4'd0; #1;
    n_checks++;
    if (rd_dat_c !== 8'd4) begin
      n_errors++;
      $display("FAIL early_oldest: got %0d, expected 4", rd_dat_c);
    end
    rd_addr = 4'd15; #1;
    n_checks++;
    if (rd_dat_c !== 8'd19) begin
      n_errors++;
      $display("FAIL early_newest: got %0d, expected 19", rd_dat_c);
    end
    test_readback("early");
  endtask

  task automatic test_rearm();
    int s, n;
    drive_cycle("rearm_arm1", 1, 0, 0, 4'd4, '0);
    for (s = 0; s < 9; s++) drive_cycle("rearm_old", 0, 1, s == 5, 4'd4, 8'(s + 100));
    drive_cycle("rearm_arm2", 1, 1, 1, 4'd2, 8'hEE);
    n = 0;
    while (done_r !== 1'b1 && n < 64) begin
      drive_cycle("rearm_new", 0, 1, n == 2, 4'd2, 8'(n + 50));
      n++;
    end
    n_checks++;
    if (n - 1 != 15) begin
      n_errors++;
      $display("FAIL rearm_done_sample: done after new sample %0d, expected 15", n - 1);
    end
    test_readback("rearm");
  endtask

  task automatic test_gapped();
    int c, s;
    drive_cycle("gapped_arm", 1, 0, 0, 4'd4, '0);
    c = 0; s = 0;
    while (done_r !== 1'b1 && c < 200) begin
      if (c % 3 == 0) begin
        drive_cycle("gapped", 0, 1, 1, 4'd4, 8'(s));
        s++;
      end else begin
        drive_cycle("gapped", 0, 0, 1, 4'd4, 8'hAA);
      end
      c++;
    end
    rd_addr = 4'd4; #1;
    n_checks++;
    if (rd_dat_c !== 8'd4) begin
      n_errors++;
      $display("FAIL gapped_trig_sample: got %0d, expected 4", rd_dat_c);
    end
    test_readback("gapped");
  endtask

  task automatic test_out_reg();
    int base;
    base = m_tidx - m_tpos;
    rd_en = 0; rd_addr = 4'd7;
    @(posedge clk); #1;
    n_checks++;
    if (rd_vld_r !== 0 || rd_dat_r !== '0) begin
      n_errors++;
      $display("FAIL outreg_idle: rd_vld=%0b rd_dat=%0h, expected 0/0", rd_vld_r, rd_dat_r);
    end
    @(negedge clk);
    rd_en = 1; #1;
    n_checks++;
    if (rd_vld_r !== 0 || rd_vld_c !== 1 || rd_dat_c !== hist[base + 7]) begin
      n_errors++;
      $display("FAIL outreg_lag_on: reg vld=%0b comb vld=%0b comb dat=%0h, expected 0/1/%0h",
               rd_vld_r, rd_vld_c, rd_dat_c, hist[base + 7]);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rd_vld_r !== 1 || rd_dat_r !== hist[base + 7]) begin
      n_errors++;
      $display("FAIL outreg_data: vld=%0b dat=%0h, expected 1/%0h", rd_vld_r, rd_dat_r, hist[base + 7]);
    end
    @(negedge clk);
    rd_en = 0; #1;
    n_checks++;
    if (rd_vld_r !== 1 || rd_vld_c !== 0) begin
      n_errors++;
      $display("FAIL outreg_lag_off: reg vld=%0b comb vld=%0b, expected 1/0", rd_vld_r, rd_vld_c);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rd_vld_r !== 0 || rd_dat_r !== '0) begin
      n_errors++;
      $display("FAIL outreg_zero: vld=%0b dat=%0h, expected 0/0", rd_vld_r, rd_dat_r);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [3:0] p;
    int c;
    bit a;
    for (int it = 0; it < 10; it++) begin
      p = (it == 0) ? 4'd0 : (it == 1) ? 4'd15 : 4'($urandom_range(0, 15));
      drive_cycle("random_arm", 1, 0, 0, p, '0);
      c = 0;
      while (!m_done && c < 600) begin
        a = ($urandom_range(0, 79) == 0);
        if (a) p = 4'($urandom_range(0, 15));
        drive_cycle("random", a, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                    p, 8'($urandom));
        c++;
      end
      if (!m_done) begin
        n_checks++; n_errors++;
        $display("FAIL random_timeout: iteration %0d window incomplete, expected done", it);
      end else begin
        test_readback("random");
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_out_reg();
    test_early_trig();
    test_rearm();
    test_gapped();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
